// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
// Imported by spi_slave and spi_shift_rx.
package spi_slave_pkg;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_shift_rx.sv
// Serial-in/parallel-out shifter with bit counter.
// done_o marks the edge on which the last bit is sampled.
module spi_shift_rx
    import spi_slave_pkg::*;
#(
    parameter int W = RX_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] word_o,
    output logic         done_o
);

    localparam int CW = $clog2(W);

    logic [W-2:0]  sr_q;
    logic [CW-1:0] cnt_q;

    assign done_o = en_i && (cnt_q == CW'(W - 1));
    assign word_o = {sr_q, bit_i};

    // Shift MSB-first; counter wraps to 0 when the word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            sr_q  <= word_o[W-2:0];
            cnt_q <= done_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: MOSI frames to parallel command words,
// read-data bytes from the RAM back out on MISO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int TCW = $clog2(TX_W);

    state_t state_q, state_d;

    logic            rx_en;
    logic            rx_fire;
    logic [RX_W-1:0] rx_word;
    logic [RX_W-1:0] rx_data_q;
    logic            rx_valid_q;
    logic            rx_done_q;
    logic            rd_seen_q;

    logic            tx_load;
    logic [TX_W-1:0] tx_sr_q;
    logic [TCW-1:0]  tx_cnt_q;
    logic            tx_busy_q;
    logic            tx_done_q;
    logic            miso_q;

    spi_shift_rx #(.W(RX_W)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (SS_n),
        .en_i   (rx_en),
        .bit_i  (MOSI),
        .word_o (rx_word),
        .done_o (rx_fire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, RX shift enable and TX load decision
    always_comb begin
        state_d = state_q;
        rx_en   = 1'b0;
        tx_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (!MOSI)          state_d = WRITE;
                else if (rd_seen_q) state_d = READ_DATA;
                else                state_d = READ_ADD;
            end
            WRITE, READ_ADD: begin
                rx_en = !rx_done_q;
            end
            READ_DATA: begin
                rx_en = !rx_done_q;
                // rx_valid cycle skipped: tx_valid may be stale
                tx_load = rx_done_q && !rx_valid_q &&
                          !tx_busy_q && !tx_done_q && tx_valid;
            end
            default: state_d = IDLE;
        endcase
        if (SS_n) begin
            state_d = IDLE;
            rx_en   = 1'b0;
            tx_load = 1'b0;
        end
    end

    // Command word capture, strobe and frame-complete flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_fire;
            if (rx_fire) rx_data_q <= rx_word;
            if (SS_n)         rx_done_q <= 1'b0;
            else if (rx_fire) rx_done_q <= 1'b1;
        end
    end

    // Remember a completed read-address frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_seen_q <= 1'b0;
        end else if (rx_fire) begin
            if (state_q == READ_ADD)  rd_seen_q <= 1'b1;
            if (state_q == READ_DATA) rd_seen_q <= 1'b0;
        end
    end

    // Read byte out on MISO, MSB first, 0 when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q    <= 1'b0;
            tx_sr_q   <= '0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else if (SS_n) begin
            miso_q    <= 1'b0;
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else if (tx_load) begin
            miso_q    <= tx_data[TX_W-1];
            tx_sr_q   <= {tx_data[TX_W-2:0], 1'b0};
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b1;
        end else if (tx_busy_q) begin
            miso_q   <= tx_sr_q[TX_W-1];
            tx_sr_q  <= {tx_sr_q[TX_W-2:0], 1'b0};
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == TCW'(TX_W - 2)) begin
                tx_busy_q <= 1'b0;
                tx_done_q <= 1'b1;
            end
        end else begin
            miso_q <= 1'b0;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave with a frame-level model
// and a small command RAM model.
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // Command RAM: tx_valid stays high once a read was served
    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    always @(posedge clk) begin
        if (rx_valid) begin
            case (rx_data[9:8])
                OP_WR_ADDR: wr_addr <= rx_data[7:0];
                OP_WR_DATA: mem[wr_addr] <= rx_data[7:0];
                OP_RD_ADDR: rd_addr <= rx_data[7:0];
                default: begin
                    tx_data  <= mem[rd_addr];
                    tx_valid <= 1'b1;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Frame-level model: edge position within the frame drives everything
    logic       exp_rxv = 1'b0;
    logic       exp_miso = 1'b0;
    logic [9:0] exp_rxd = '0;
    bit         m_act = 0;
    bit         m_rdseen = 0;
    bit         m_wait = 0;
    int         m_pos = 0;
    int         m_kind = 0;
    logic [9:0] m_bits = '0;
    bit         m_txq [$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_act = 0; m_rdseen = 0; m_wait = 0; m_pos = 0;
            m_txq.delete();
            exp_rxv = 1'b0; exp_miso = 1'b0; exp_rxd = '0;
        end else begin
            exp_rxv  = 1'b0;
            exp_miso = 1'b0;
            if (!m_act) begin
                if (!SS_n) begin
                    m_act = 1; m_pos = 0; m_wait = 0;
                    m_txq.delete();
                end
            end else if (SS_n) begin
                m_act = 0; m_wait = 0;
                m_txq.delete();
            end else begin
                m_pos++;
                if (m_pos == 1) begin
                    m_kind = MOSI ? (m_rdseen ? 2 : 1) : 0;
                end else if (m_pos <= 11) begin
                    m_bits = {m_bits[8:0], MOSI};
                    if (m_pos == 11) begin
                        exp_rxv = 1'b1;
                        exp_rxd = m_bits;
                        if (m_kind == 1) m_rdseen = 1;
                        if (m_kind == 2) begin
                            m_rdseen = 0;
                            m_wait = 1;
                        end
                    end
                end else if (m_kind == 2) begin
                    if (m_pos >= 13 && m_wait && tx_valid) begin
                        m_wait = 0;
                        for (int i = 7; i >= 0; i--)
                            m_txq.push_back(tx_data[i]);
                    end
                    if (m_txq.size() > 0) exp_miso = m_txq.pop_front();
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("cyc_rx_valid", rx_valid, exp_rxv);
        chk("cyc_miso", MISO, exp_miso);
        chk("cyc_rx_data", rx_data, exp_rxd);
    end

    // One SPI frame; tail cycles keep SS_n low after the data bits
    task automatic frame(input logic sel, input logic [9:0] w,
                         input int nbits, input int tail, input int rst_at,
                         output logic [9:0] rxd, output int nrxv,
                         output logic [7:0] rbyte);
        nrxv = 0; rxd = '0; rbyte = '0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = sel;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (rx_valid) nrxv++;
            MOSI = w[9-i];
        end
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                nrxv++;
                rxd = rx_data;
            end
            if (k >= 2 && k <= 9) rbyte = {rbyte[6:0], MISO};
            if (k == rst_at) begin
                chk("pre_reset_miso", MISO, 1);
                #2 rst_n = 1'b0;
                #1;
                chk("rst_miso", MISO, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
                SS_n = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            MOSI = ~MOSI;
        end
        @(negedge clk);
        if (rx_valid) nrxv++;
        SS_n = 1'b1; MOSI = 1'b0;
    endtask

    initial begin
        logic [9:0] d;
        int         n;
        logic [7:0] b;
        repeat (2) @(negedge clk);
        chk("reset_miso", MISO, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        rst_n = 1'b1;

        frame(1'b0, 10'h0A5, 10, 3, -1, d, n, b);
        chk("wr_addr_rxd", d, 10'h0A5);
        chk("wr_addr_pulses", n, 1);

        frame(1'b0, 10'h13C, 10, 3, -1, d, n, b);
        chk("wr_data_rxd", d, 10'h13C);
        chk("wr_data_pulses", n, 1);
        chk("ram_store", mem[8'hA5], 8'h3C);

        frame(1'b1, 10'h2A5, 10, 3, -1, d, n, b);
        chk("rd_addr_rxd", d, 10'h2A5);
        chk("rd_addr_miso", b, 8'h00);

        frame(1'b1, 10'h300, 10, 12, -1, d, n, b);
        chk("rd_data_rxd", d, 10'h300);
        chk("rd_data_byte", b, 8'h3C);

        frame(1'b0, 10'h1C3, 10, 3, -1, d, n, b);
        frame(1'b1, 10'h2A5, 10, 3, -1, d, n, b);
        chk("stale_tx_valid_high", tx_valid, 1);
        chk("stale_tx_data_old", tx_data, 8'h3C);
        frame(1'b1, 10'h300, 10, 12, -1, d, n, b);
        chk("stale_byte", b, 8'hC3);

        frame(1'b1, 10'h2A5, 10, 3, -1, d, n, b);
        frame(1'b1, 10'h300, 6, 0, -1, d, n, b);
        chk("abort_pulses", n, 0);
        frame(1'b1, 10'h300, 10, 12, -1, d, n, b);
        chk("after_abort_rxd", d, 10'h300);
        chk("after_abort_pulses", n, 1);
        chk("after_abort_byte", b, 8'hC3);

        frame(1'b1, 10'h2A5, 10, 3, -1, d, n, b);
        frame(1'b1, 10'h300, 10, 12, 3, d, n, b);
        frame(1'b1, 10'h2A5, 10, 12, -1, d, n, b);
        chk("post_rst_rd_addr_rxd", d, 10'h2A5);
        chk("post_rst_rd_addr_byte", b, 8'h00);
        frame(1'b1, 10'h300, 10, 12, -1, d, n, b);
        chk("post_rst_rd_data_byte", b, 8'hC3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end for the single-port command RAM. Converts SPI frames (MOSI, SS_n) into 10-bit parallel command words with a one-cycle rx_valid strobe.
- For read-data commands, waits for the RAM's tx_valid, captures the 8-bit read byte and shifts it out on MISO MSB-first.
- The SPI bit clock is clk itself; all MOSI sampling and MISO updates happen on posedge clk.

Parameters:
- RX_W, 10, parallel command width: 2-bit opcode in [9:8], 8-bit payload in [7:0].
- TX_W, 8, read-data width shifted out on MISO.

Ports:
- clk  in  1  system clock; also the SPI bit clock.
- rst_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  slave select, active-low; frame is active while low.
- MOSI  in  1  serial data in, sampled on posedge clk.
- MISO  out  1  serial data out, registered.
- rx_data  out  RX_W  assembled command word to the RAM.
- rx_valid  out  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  in  TX_W  read byte from the RAM.
- tx_valid  in  1  RAM read-data valid (may remain high after the first read).

Behaviour:
- Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, rd_addr_seen=0, all counters 0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: when SS_n=0 at a posedge, go to CHK_CMD.
- CHK_CMD: sample MOSI as the select bit.
  - Select bit 0 -> WRITE.
  - Select bit 1 and rd_addr_seen=0 -> READ_ADD.
  - Select bit 1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift the next 10 MOSI bits MSB-first into the shift register (4-bit counter, 0..9).
  - After the 10th bit is sampled, the register moves to rx_data and rx_valid=1 for exactly the next cycle.
  - rx_data holds that value until the next completed frame.
- rd_addr_seen is set when a READ_ADD frame completes its 10 bits and cleared when a READ_DATA frame completes its 10 bits.
- The block does not check rx_data[9:8] against the state; the RAM decodes the opcode.
- READ_DATA transmit phase (after the rx_valid pulse):
  - Ignore tx_valid during the rx_valid cycle itself, because the RAM's tx_valid can stay high from an earlier read.
  - On the first posedge after that cycle where tx_valid=1, load tx_data into the TX shift register.
  - Drive MISO=tx_data[7] from that edge, then bits 6..0 on the next 7 edges (3-bit counter).
  - Drive MISO=0 after the 8th bit, and while waiting for tx_valid.
- After a frame finishes (rx_valid issued, plus 8 TX bits in READ_DATA), stay in the current state and ignore MOSI until SS_n=1.
- SS_n=1 at any posedge in any non-IDLE state:
  - Go to IDLE on that edge and drive MISO=0.
  - Discard partial RX and TX shifts: no rx_valid, rd_addr_seen unchanged.
  - If rx_valid was already issued for that frame, it is not retracted.
- SS_n low continuously across frames is not a new frame; a new frame needs SS_n high for at least 1 cycle.
- MISO is 0 whenever no bit is being transmitted.
- Async reset mid-frame: everything returns to reset values immediately.

Decomposition:
- Shared package:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - RX_W and TX_W defaults.
- One sub-module is natural: spi_shift_rx, a 10-bit serial-in/parallel-out shifter with bit counter, clear and done pulse. The TX shifter stays inline.
- Top-level integration (spi_slave plus RAM) is a separate wrapper, out of scope here.

Test Plan:
- Write address: select 0 then bits 00_1010_0101 -> rx_valid pulses one cycle after the 10th bit with rx_data=10'h0A5; rd_addr_seen stays 0; MISO=0 throughout.
- Write data: select 0 then 01_0011_1100 -> rx_data=10'h13C with a single rx_valid pulse; a RAM model stores 8'h3C at 8'hA5.
- Read address then read data:
  - Select 1 with 10_1010_0101 -> rx_data=10'h2A5, rd_addr_seen=1.
  - Next frame: select 1 with 11_0000_0000 -> rx_data=10'h300, rd_addr_seen=0.
  - RAM model raises tx_valid one cycle later with tx_data=8'h3C -> MISO shows 0,0,1,1,1,1,0,0 on consecutive cycles, then 0.
- Stale tx_valid: tx_valid held high from a prior read, second READ_DATA with RAM returning 8'hC3 one cycle after rx_valid -> MISO carries C3, not the stale byte.
- Abort: SS_n goes high after 6 of 10 bits -> no rx_valid, state IDLE next cycle, rd_addr_seen unchanged; the following full frame decodes correctly.
- Reset: rst_n asserted mid-TX (bit 3 of 8) -> MISO=0, rx_valid=0 and state IDLE immediately, with no clk edge needed.
